// File: rtl/sprite_scheduler.sv
// Sprite scheduler: owns the sprite register table and, once per video frame, walks it and
// issues every active entry to graphics with a ready-paced handshake. Optional: SPRITE_ANIM_EN.
module sprite_scheduler #(
  parameter  int MAX_SPRITES   = 16,
  parameter  int CANVAS_WIDTH  = 360,
  parameter  int CANVAS_HEIGHT = 720,
  parameter  int NUM_FRAMES    = 18,
  parameter  int ANIM_SHIFT    = 3,
  localparam int IDX_W         = $clog2(MAX_SPRITES),
  localparam int X_W           = $clog2(CANVAS_WIDTH),
  localparam int Y_W           = $clog2(CANVAS_HEIGHT),
  localparam int F_W           = $clog2(NUM_FRAMES)
) (
  input  logic             clk_pixel,
  input  logic             sys_rst,
  input  logic [5:0]       frame_count,
  input  logic             tbl_we,
  input  logic [IDX_W-1:0] tbl_addr,
  input  logic             tbl_active,
  input  logic [X_W-1:0]   tbl_x,
  input  logic [Y_W-1:0]   tbl_y,
  input  logic [F_W-1:0]   tbl_frame,
  input  logic [1:0]       tbl_anim_len,
  input  logic             sprite_ready,
  output logic             sprite_valid,
  output logic [X_W-1:0]   sprite_x,
  output logic [Y_W-1:0]   sprite_y,
  output logic [F_W-1:0]   sprite_frame_number,
  output logic             pass_done,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, SCAN, WAIT_LO, WAIT_HI} state_t;

  localparam logic [IDX_W:0] IDX_END      = (IDX_W + 1)'(MAX_SPRITES);
  localparam logic [F_W:0]   NUM_FRAMES_W = (F_W + 1)'(NUM_FRAMES);

  state_t                 state_reg;
  logic [IDX_W:0]         idx_reg;
  logic                   restart_reg;
  logic [5:0]             prev_frame_count_reg;
  logic                   new_frame_reg;
  logic                   sync_reg;

  logic [MAX_SPRITES-1:0] active_reg;
  logic [MAX_SPRITES-1:0] active_next;
  logic [X_W-1:0]         x_mem     [MAX_SPRITES];
  logic [Y_W-1:0]         y_mem     [MAX_SPRITES];
  logic [F_W-1:0]         frame_mem [MAX_SPRITES];

  logic [IDX_W-1:0]       rd_idx;
  logic                   past_end;
  logic                   cur_active;
  logic [F_W-1:0]         issue_frame;

  // Only the enable flags need reset; coordinates are don't-care while inactive.
  for (genvar gi = 0; gi < MAX_SPRITES; gi++) begin : g_active
    assign active_next[gi] = (tbl_we && tbl_addr == IDX_W'(gi)) ? tbl_active : active_reg[gi];
  end

  always_ff @(posedge clk_pixel or posedge sys_rst) begin
    if (sys_rst) begin
      active_reg <= '0;
    end else begin
      active_reg <= active_next;
    end
  end

`ifdef SPRITE_ANIM_EN
  logic [1:0]            anim_mem [MAX_SPRITES];
  logic [5-ANIM_SHIFT:0] anim_step;
  logic [1:0]            anim_offset;
  logic [F_W:0]          frame_sum;
`endif

  always_ff @(posedge clk_pixel) begin
    if (tbl_we) begin
      x_mem[tbl_addr]     <= tbl_x;
      y_mem[tbl_addr]     <= tbl_y;
      frame_mem[tbl_addr] <= tbl_frame;
`ifdef SPRITE_ANIM_EN
      anim_mem[tbl_addr]  <= tbl_anim_len;
`endif
    end
  end

  assign rd_idx     = idx_reg[IDX_W-1:0];
  assign past_end   = (idx_reg >= IDX_END);
  assign cur_active = active_reg[rd_idx];

`ifdef SPRITE_ANIM_EN
  assign anim_step = frame_count[5:ANIM_SHIFT];

  // Cycle length is 1..4, so the modulo reduces to a small case on the stored length.
  always_comb begin
    anim_offset = 2'd0;
    case (anim_mem[rd_idx])
      2'd1:    anim_offset = {1'b0, anim_step[0]};
      2'd2:    anim_offset = 2'(anim_step % 3);
      2'd3:    anim_offset = anim_step[1:0];
      default: anim_offset = 2'd0;
    endcase
  end

  assign frame_sum   = {1'b0, frame_mem[rd_idx]} + {{(F_W - 1){1'b0}}, anim_offset};
  // Fall back to the base frame rather than index past the end of the spritesheet.
  assign issue_frame = (frame_sum >= NUM_FRAMES_W) ? frame_mem[rd_idx] : frame_sum[F_W-1:0];
`else
  localparam int unused_anim_shift = ANIM_SHIFT;
  logic unused_anim_len;
  assign unused_anim_len = ^tbl_anim_len;
  assign issue_frame     = frame_mem[rd_idx];
`endif

  // sync_reg masks the first cycle after reset so the current frame_count is taken as the baseline.
  always_ff @(posedge clk_pixel or posedge sys_rst) begin
    if (sys_rst) begin
      prev_frame_count_reg <= '0;
      new_frame_reg        <= 1'b0;
      sync_reg             <= 1'b0;
    end else begin
      prev_frame_count_reg <= frame_count;
      new_frame_reg        <= sync_reg && (frame_count != prev_frame_count_reg);
      sync_reg             <= 1'b1;
    end
  end

  always_ff @(posedge clk_pixel or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg           <= IDLE;
      idx_reg             <= '0;
      restart_reg         <= 1'b0;
      sprite_valid        <= 1'b0;
      sprite_x            <= '0;
      sprite_y            <= '0;
      sprite_frame_number <= '0;
      pass_done           <= 1'b0;
      overrun             <= 1'b0;
    end else begin
      sprite_valid <= 1'b0;
      pass_done    <= 1'b0;
      overrun      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (new_frame_reg) begin
            state_reg <= SCAN;
            idx_reg   <= '0;
          end
        end
        SCAN: begin
          if (new_frame_reg) begin
            overrun <= 1'b1;
            idx_reg <= '0;
          end else if (past_end) begin
            pass_done <= 1'b1;
            state_reg <= IDLE;
          end else if (!cur_active) begin
            idx_reg <= idx_reg + 1'b1;
          end else if (sprite_ready) begin
            sprite_x            <= x_mem[rd_idx];
            sprite_y            <= y_mem[rd_idx];
            sprite_frame_number <= issue_frame;
            sprite_valid        <= 1'b1;
            state_reg           <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          // A frame change here is remembered; the open handshake must still finish.
          if (new_frame_reg) begin
            overrun     <= 1'b1;
            restart_reg <= 1'b1;
          end
          if (!sprite_ready) begin
            state_reg <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (new_frame_reg) begin
            overrun     <= 1'b1;
            restart_reg <= 1'b1;
          end
          if (sprite_ready) begin
            state_reg   <= SCAN;
            restart_reg <= 1'b0;
            idx_reg     <= (restart_reg || new_frame_reg) ? '0 : idx_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          idx_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler: table-driven single-sprite vectors, then hand-written
// sequences for ordering, table-write races, slow graphics, empty table, overrun and reset.
`timescale 1ns/1ps
module tb_sprite_scheduler;
  localparam int MAX_SPRITES = 16;

  logic       clk_pixel    = 1'b0;
  logic       sys_rst      = 1'b1;
  logic [5:0] frame_count  = 6'd0;
  logic       tbl_we       = 1'b0;
  logic [3:0] tbl_addr     = 4'd0;
  logic       tbl_active   = 1'b0;
  logic [8:0] tbl_x        = 9'd0;
  logic [9:0] tbl_y        = 10'd0;
  logic [4:0] tbl_frame    = 5'd0;
  logic [1:0] tbl_anim_len = 2'd0;
  logic       sprite_ready = 1'b1;
  logic       sprite_valid;
  logic [8:0] sprite_x;
  logic [9:0] sprite_y;
  logic [4:0] sprite_frame_number;
  logic       pass_done;
  logic       overrun;

  sprite_scheduler dut (
    .clk_pixel(clk_pixel), .sys_rst(sys_rst), .frame_count(frame_count),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_active(tbl_active),
    .tbl_x(tbl_x), .tbl_y(tbl_y), .tbl_frame(tbl_frame), .tbl_anim_len(tbl_anim_len),
    .sprite_ready(sprite_ready), .sprite_valid(sprite_valid), .sprite_x(sprite_x),
    .sprite_y(sprite_y), .sprite_frame_number(sprite_frame_number),
    .pass_done(pass_done), .overrun(overrun)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    int x;
    int y;
    int f;
    int cyc;
  } issue_t;

  // idx, x, y, base frame, anim_len, frame_count, expected frame (anim on), expected frame (anim off)
  typedef struct {
    int idx;
    int x;
    int y;
    int f;
    int len;
    int fc;
    int exp_anim;
    int exp_base;
  } vec_t;

  issue_t issue_q[$];
  vec_t   vecs[8];
  int     cyc = 0, pass_cnt = 0, ovr_cnt = 0, viol_cnt = 0, pass_cyc = 0;
  int     busy_len = 1, busy = 0, chg_cyc = 0;
  int     n_checks = 0, n_errors = 0;

  // Graphics model plus monitor: ready drops after each accepted sprite for busy_len cycles.
  initial begin
    issue_t it;
    forever begin
      @(posedge clk_pixel);
      #1;
      cyc++;
      if (sys_rst) begin
        busy         = 0;
        sprite_ready = 1'b1;
      end else begin
        if (pass_done) begin
          pass_cnt++;
          pass_cyc = cyc;
        end
        if (overrun) ovr_cnt++;
        if (sprite_valid) begin
          if (!sprite_ready) viol_cnt++;
          it.x = int'(sprite_x);
          it.y = int'(sprite_y);
          it.f = int'(sprite_frame_number);
          it.cyc = cyc;
          issue_q.push_back(it);
          $display("issue cyc=%0d x=%0d y=%0d frame=%0d ready=%0b", cyc, it.x, it.y, it.f, sprite_ready);
        end
        if (busy > 0) begin
          busy--;
          if (busy == 0) sprite_ready = 1'b1;
        end else if (sprite_valid) begin
          sprite_ready = 1'b0;
          busy         = busy_len;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_pixel);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic write_entry(input int idx, input bit act, input int x, input int y,
                             input int f, input int len);
    tbl_addr     = 4'(idx);
    tbl_active   = act;
    tbl_x        = 9'(x);
    tbl_y        = 10'(y);
    tbl_frame    = 5'(f);
    tbl_anim_len = 2'(len);
    tbl_we       = 1'b1;
    tick();
    tbl_we       = 1'b0;
    tbl_active   = 1'b0;
  endtask

  task automatic start_frame(input int fc);
    issue_q.delete();
    frame_count = 6'(fc);
    chg_cyc     = cyc;
  endtask

  task automatic wait_pass(input int max_cycles, input string name);
    int start;
    int n;
    start = pass_cnt;
    n = 0;
    while (pass_cnt == start && n < max_cycles) begin
      tick();
      n++;
    end
    check(name, pass_cnt - start, 1);
  endtask

  initial begin
    int exp_f;
    int n;
    int ovr0;
    int p0;

    vecs[0] = '{0,   0,   0,  0, 0,  1,  0,  0};
    vecs[1] = '{15, 359, 719, 17, 0,  2, 17, 17};
    vecs[2] = '{7,  123, 456,  4, 2,  8,  5,  4};
    vecs[3] = '{7,  123, 456,  4, 2, 16,  6,  4};
    vecs[4] = '{7,  123, 456,  4, 2, 24,  4,  4};
    vecs[5] = '{3,   50,  60, 16, 3,  8, 17, 16};
    vecs[6] = '{3,   50,  60, 16, 3, 16, 16, 16};
    vecs[7] = '{9,  200, 300, 10, 1, 56, 11, 10};

    // Reset state
    repeat (3) tick();
    check("reset_outputs", {sprite_valid, sprite_x, sprite_y, sprite_frame_number, pass_done, overrun}, 0);
    sys_rst = 1'b0;
    repeat (10) tick();
    check("reset_no_issue", issue_q.size(), 0);
    check("reset_no_pass", pass_cnt, 0);

    // Single-sprite vectors: coordinates, frame arithmetic, and issue latency of 3 + index
    for (int i = 0; i < 8; i++) begin
`ifdef SPRITE_ANIM_EN
      exp_f = vecs[i].exp_anim;
`else
      exp_f = vecs[i].exp_base;
`endif
      write_entry(vecs[i].idx, 1'b1, vecs[i].x, vecs[i].y, vecs[i].f, vecs[i].len);
      start_frame(vecs[i].fc);
      wait_pass(100, $sformatf("vec%0d_pass", i));
      check($sformatf("vec%0d_count", i), issue_q.size(), 1);
      if (issue_q.size() == 1) begin
        check($sformatf("vec%0d_x", i), issue_q[0].x, vecs[i].x);
        check($sformatf("vec%0d_y", i), issue_q[0].y, vecs[i].y);
        check($sformatf("vec%0d_frame", i), issue_q[0].f, exp_f);
        check($sformatf("vec%0d_latency", i), issue_q[0].cyc - chg_cyc, 3 + vecs[i].idx);
      end
      write_entry(vecs[i].idx, 1'b0, 0, 0, 0, 0);
    end

    // Two entries issued in ascending order, outputs held after the pass
    write_entry(2, 1'b1, 10, 20, 3, 0);
    write_entry(5, 1'b1, 100, 600, 7, 0);
    start_frame(33);
    wait_pass(200, "order_pass");
    check("order_count", issue_q.size(), 2);
    if (issue_q.size() == 2) begin
      check("order_first_x", issue_q[0].x, 10);
      check("order_first_y", issue_q[0].y, 20);
      check("order_first_f", issue_q[0].f, 3);
      check("order_second_x", issue_q[1].x, 100);
      check("order_second_y", issue_q[1].y, 600);
      check("order_second_f", issue_q[1].f, 7);
    end
    repeat (3) tick();
    check("hold_x_after_pass", sprite_x, 100);
    write_entry(2, 1'b0, 0, 0, 0, 0);
    write_entry(5, 1'b0, 0, 0, 0, 0);

    // Write to the entry under the walker issues old contents; a write ahead is picked up
    write_entry(4, 1'b1, 70, 80, 1, 0);
    start_frame(34);
    repeat (6) tick();
    write_entry(4, 1'b1, 77, 88, 2, 0);
    write_entry(10, 1'b1, 111, 222, 9, 0);
    wait_pass(200, "race_pass");
    check("race_count", issue_q.size(), 2);
    if (issue_q.size() == 2) begin
      check("race_old_x", issue_q[0].x, 70);
      check("race_old_f", issue_q[0].f, 1);
      check("race_ahead_x", issue_q[1].x, 111);
    end
    start_frame(35);
    wait_pass(200, "race_next_pass");
    check("race_next_count", issue_q.size(), 2);
    if (issue_q.size() == 2) begin
      check("race_new_x", issue_q[0].x, 77);
      check("race_new_y", issue_q[0].y, 88);
    end

    // Slow graphics: 4096 busy cycles per sprite
    busy_len = 4096;
    start_frame(36);
    wait_pass(12000, "slow_pass");
    check("slow_count", issue_q.size(), 2);
    if (issue_q.size() == 2) begin
      check("slow_spacing", (issue_q[1].cyc - issue_q[0].cyc) > 4096, 1);
    end
    check("slow_no_issue_while_busy", viol_cnt, 0);
    busy_len = 1;

    // Empty table: no issue, pass_done after register + IDLE exit + MAX_SPRITES+1 scan cycles
    write_entry(4, 1'b0, 0, 0, 0, 0);
    write_entry(10, 1'b0, 0, 0, 0, 0);
    start_frame(37);
    wait_pass(100, "empty_pass");
    check("empty_no_issue", issue_q.size(), 0);
    check("empty_pass_timing", pass_cyc - chg_cyc, MAX_SPRITES + 3);

    // Overrun during the 3rd of 8 sprites
    for (int i = 0; i < 8; i++) write_entry(i, 1'b1, i * 10 + 5, i + 1, i, 0);
    busy_len = 5;
    ovr0 = ovr_cnt;
    start_frame(38);
    n = 0;
    while (issue_q.size() < 3 && n < 500) begin
      tick();
      n++;
    end
    check("ovr_third_issue", issue_q.size(), 3);
    frame_count = 6'd39;
    wait_pass(1000, "ovr_pass");
    check("ovr_pulses", ovr_cnt - ovr0, 1);
    check("ovr_count", issue_q.size(), 11);
    if (issue_q.size() == 11) begin
      check("ovr_third_x", issue_q[2].x, 25);
      check("ovr_restart_x", issue_q[3].x, 5);
      check("ovr_last_x", issue_q[10].x, 75);
    end
    check("ovr_no_issue_while_busy", viol_cnt, 0);

    // Reset while waiting for graphics to finish
    busy_len = 20;
    start_frame(40);
    n = 0;
    while (issue_q.size() < 1 && n < 100) begin
      tick();
      n++;
    end
    check("rst_first_issue", issue_q.size(), 1);
    repeat (3) tick();
    check("rst_pre_x", sprite_x, 5);
    #1 sys_rst = 1'b1;
    #1;
    check("rst_async_outputs", {sprite_valid, sprite_x, sprite_y, sprite_frame_number, pass_done, overrun}, 0);
    tick();
    sys_rst = 1'b0;
    busy_len = 1;
    issue_q.delete();
    p0 = pass_cnt;
    write_entry(0, 1'b1, 5, 1, 0, 0);
    repeat (30) tick();
    check("rst_quiet_issue", issue_q.size(), 0);
    check("rst_quiet_pass", pass_cnt - p0, 0);
    start_frame(41);
    wait_pass(100, "rst_next_pass");
    check("rst_next_count", issue_q.size(), 1);
    if (issue_q.size() == 1) check("rst_next_x", issue_q[0].x, 5);
    check("total_no_issue_while_busy", viol_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
